fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencer between the exec unit and the fetch unit of the 12-bit processor.
- Owns fetch's deque_i, restart_i and restart_addr_i.
- Handles boot, taken-branch redirects, stalls and halt/start.
- Drops wrong-path instructions so decode only ever sees a clean, in-order stream.

Parameters:
- I_WIDTH, 12, instruction width
- A_WIDTH, 8, instruction address width
- BOOT_ADDR, 0, restart address after reset
- CNT_WIDTH, 16, issued-instruction counter width

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  leave HALT; restart at start_addr_i
- start_addr_i  in  A_WIDTH  restart target for start_i
- stall_i  in  1  decode cannot accept this cycle
- branch_i  in  1  taken-branch redirect request
- branch_addr_i  in  A_WIDTH  redirect target
- halt_i  in  1  halt instruction retired
- fetch_deque_o  out  1  to fetch deque_i
- fetch_restart_o  out  1  to fetch restart_i
- fetch_restart_addr_o  out  A_WIDTH  to fetch restart_addr_i
- fetch_instr_i  in  I_WIDTH  from fetch instruction_data_o
- fetch_addr_i  in  A_WIDTH  from fetch instruction_addr_o
- fetch_ready_i  in  1  from fetch instruction_ready_o
- instr_valid_o  out  1  instruction presented to decode
- instr_o  out  I_WIDTH  instruction to decode
- instr_addr_o  out  A_WIDTH  its address
- halted_o  out  1  controller in HALT
- issued_count_o  out  CNT_WIDTH  accepted-instruction count

Behaviour:
- States: RESTART, WAIT, RUN, HALT. State, target register, fetch_restart_o, fetch_restart_addr_o and the counter are registers; all other outputs are combinational from state and inputs.
- Reset (rst_n=0, asynchronous):
  - state=RESTART, target=BOOT_ADDR, fetch_restart_addr_o=BOOT_ADDR, issued_count_o=0.
  - fetch_restart_o=0, fetch_deque_o=0, instr_valid_o=0, halted_o=0.
  - Reset mid-operation abandons everything immediately.
- RESTART (exactly 1 cycle):
  - fetch_restart_o=1, fetch_restart_addr_o=target.
  - Next state: WAIT.
- WAIT:
  - fetch_restart_o=0, instr_valid_o=0.
  - If fetch_ready_i=1 and fetch_addr_i!=target: fetch_deque_o=1 (discard stale entry).
  - If fetch_ready_i=1 and fetch_addr_i==target: no deque; next state RUN.
- RUN:
  - instr_valid_o=fetch_ready_i; instr_o=fetch_instr_i; instr_addr_o=fetch_addr_i.
  - fetch_deque_o = fetch_ready_i & ~stall_i.
  - Each deque increments issued_count_o, which saturates at all-ones and is cleared only by reset.
- HALT:
  - halted_o=1; fetch_deque_o=0; instr_valid_o=0.
  - start_i=1: target<=start_addr_i; next state RESTART; halted_o drops the following cycle.
- Event priority in RESTART/WAIT/RUN: halt_i > branch_i > stall_i/normal.
  - halt_i=1: next state HALT; instr_valid_o=0 and fetch_deque_o=0 that cycle.
  - branch_i=1 (no halt): target<=branch_addr_i; next state RESTART; instr_valid_o=0 and fetch_deque_o=0 that cycle (wrong path). branch_i overrides stall_i.
  - branch_i while already in RESTART: re-enter RESTART with the new target, so a second restart pulse follows.
- HALT ignores branch_i, halt_i and stall_i. start_i outside HALT is ignored.
- Latency:
  - branch_i cycle N → fetch_restart_o in cycle N+1.
  - Earliest valid target instruction in cycle N+3 (WAIT match at N+2, RUN at N+3).

Decomposition:
- Package fetch_ctrl_pkg holds:
  - state enum (RESTART, WAIT, RUN, HALT)
  - default widths I_WIDTH/A_WIDTH/CNT_WIDTH
  - BOOT_ADDR constant
- One sub-module, sat_counter (parameter WIDTH; inputs clk, rst_n, inc_i; output count_o), saturating increment with async clear.

Test Plan:
- Boot: release rst_n; model fetch presents addr 0x00 ready 2 cycles later → one fetch_restart_o pulse with addr 0x00; WAIT→RUN; instr_valid_o with instr_addr_o=0x00; count goes 0→1 on first deque.
- Stall: in RUN, stall_i=1 for 3 cycles with fetch_ready_i=1 → instr_valid_o=1, fetch_deque_o=0, count constant, instr_addr_o unchanged; deque resumes when stall drops.
- Branch: in RUN, branch_i=1, addr 0x40, same cycle as stall_i=1 → no deque or valid that cycle; restart pulse addr 0x40 next cycle; stale ready entries at 0x05/0x06 are dequeued with instr_valid_o=0; first valid shows instr_addr_o=0x40.
- Halt vs branch: halt_i=1 and branch_i=1 together → HALT, halted_o=1, no restart pulse; later start_i=1 with 0x80 → restart pulse addr 0x80, halted_o=0, valid at 0x80.
- Reset mid-WAIT: assert rst_n=0 asynchronously between clock edges → outputs clear immediately; count=0; after release, restart to BOOT_ADDR.
- Saturation: CNT_WIDTH=4, 20 accepted instructions → issued_count_o stops at 0xF.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default sizes for the fetch sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESTART = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RUN     = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    localparam int DEF_I_WIDTH   = 12;
    localparam int DEF_A_WIDTH   = 8;
    localparam int DEF_CNT_WIDTH = 16;
    localparam int BOOT_ADDR_D   = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (inc_i && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign count_o = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Sequencer between exec and fetch: boot, redirects, stalls, halt/start;
// filters wrong-path entries so decode sees a clean in-order stream.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int I_WIDTH   = DEF_I_WIDTH,
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int BOOT_ADDR = BOOT_ADDR_D,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [A_WIDTH-1:0]   start_addr_i,
    input  logic                 stall_i,
    input  logic                 branch_i,
    input  logic [A_WIDTH-1:0]   branch_addr_i,
    input  logic                 halt_i,
    output logic                 fetch_deque_o,
    output logic                 fetch_restart_o,
    output logic [A_WIDTH-1:0]   fetch_restart_addr_o,
    input  logic [I_WIDTH-1:0]   fetch_instr_i,
    input  logic [A_WIDTH-1:0]   fetch_addr_i,
    input  logic                 fetch_ready_i,
    output logic                 instr_valid_o,
    output logic [I_WIDTH-1:0]   instr_o,
    output logic [A_WIDTH-1:0]   instr_addr_o,
    output logic                 halted_o,
    output logic [CNT_WIDTH-1:0] issued_count_o
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [A_WIDTH-1:0] r_target;
    logic [A_WIDTH-1:0] w_target_nxt;
    logic               r_restart;
    logic               w_deque;
    logic               w_valid;
    logic               w_accept;

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_deque      = 1'b0;
        w_valid      = 1'b0;
        w_accept     = 1'b0;
        if (r_state == ST_HALT) begin
            if (start_i) begin
                w_state_nxt  = ST_RESTART;
                w_target_nxt = start_addr_i;
            end
        end else if (halt_i) begin
            w_state_nxt = ST_HALT;
        end else if (branch_i) begin
            w_state_nxt  = ST_RESTART;
            w_target_nxt = branch_addr_i;
        end else begin
            case (r_state)
                // Straight out of reset the pulse register is still low, so
                // RESTART holds one extra cycle to issue the boot pulse.
                ST_RESTART: if (r_restart) w_state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (fetch_ready_i) begin
                        if (fetch_addr_i == r_target) w_state_nxt = ST_RUN;
                        else                          w_deque     = 1'b1;
                    end
                end
                ST_RUN: begin
                    w_valid  = fetch_ready_i;
                    w_deque  = fetch_ready_i & ~stall_i;
                    w_accept = w_deque;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RESTART;
            r_target  <= A_WIDTH'(BOOT_ADDR);
            r_restart <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_target  <= w_target_nxt;
            r_restart <= (w_state_nxt == ST_RESTART);
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (w_accept),
        .count_o (issued_count_o)
    );

    assign fetch_deque_o        = w_deque;
    assign fetch_restart_o      = r_restart;
    assign fetch_restart_addr_o = r_target;
    assign instr_valid_o        = w_valid;
    assign instr_o              = fetch_instr_i;
    assign instr_addr_o         = fetch_addr_i;
    assign halted_o             = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl, with hand sequences for reset and saturation.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 0, stall_i = 0, branch_i = 0, halt_i = 0;
    logic [7:0]  start_addr_i = 0, branch_addr_i = 0;
    logic        fetch_deque_o, fetch_restart_o, fetch_ready_i = 0;
    logic [7:0]  fetch_restart_addr_o, fetch_addr_i = 0, instr_addr_o;
    logic [11:0] fetch_instr_i = 0, instr_o;
    logic        instr_valid_o, halted_o;
    logic [3:0]  issued_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.I_WIDTH(12), .A_WIDTH(8), .BOOT_ADDR(0), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_i(start_i), .start_addr_i(start_addr_i),
        .stall_i(stall_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .halt_i(halt_i),
        .fetch_deque_o(fetch_deque_o), .fetch_restart_o(fetch_restart_o),
        .fetch_restart_addr_o(fetch_restart_addr_o),
        .fetch_instr_i(fetch_instr_i), .fetch_addr_i(fetch_addr_i),
        .fetch_ready_i(fetch_ready_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_addr_o(instr_addr_o),
        .halted_o(halted_o), .issued_count_o(issued_count_o)
    );

    typedef struct {
        int stall, br, baddr, halt, start, saddr, rdy, faddr, finstr;
        int deq, rst, raddr, vld, hlt, cnt;
    } vec_t;

    vec_t vt[29];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start_i = 0; stall_i = 0; branch_i = 0; halt_i = 0;
        start_addr_i = 0; branch_addr_i = 0;
    endtask

    initial begin
        //        stall br baddr  halt st saddr rdy faddr finstr | deq rst raddr vld hlt cnt
        vt[0]  = '{0,0,'h00, 0,0,'h00, 0,'h00,'h000,  0,0,'h00,0,0,0};
        vt[1]  = '{0,0,'h00, 0,0,'h00, 0,'h00,'h000,  0,1,'h00,0,0,0};
        vt[2]  = '{0,0,'h00, 0,0,'h00, 1,'h00,'h111,  0,0,'h00,0,0,0};
        vt[3]  = '{0,0,'h00, 0,0,'h00, 1,'h00,'h111,  1,0,'h00,1,0,0};
        vt[4]  = '{0,0,'h00, 0,0,'h00, 1,'h01,'h112,  1,0,'h00,1,0,1};
        vt[5]  = '{1,0,'h00, 0,0,'h00, 1,'h02,'h113,  0,0,'h00,1,0,2};
        vt[6]  = '{1,0,'h00, 0,0,'h00, 1,'h02,'h113,  0,0,'h00,1,0,2};
        vt[7]  = '{1,0,'h00, 0,0,'h00, 1,'h02,'h113,  0,0,'h00,1,0,2};
        vt[8]  = '{0,0,'h00, 0,0,'h00, 1,'h02,'h113,  1,0,'h00,1,0,2};
        vt[9]  = '{0,0,'h00, 0,0,'h00, 1,'h03,'h114,  1,0,'h00,1,0,3};
        vt[10] = '{1,1,'h40, 0,0,'h00, 1,'h04,'h115,  0,0,'h00,0,0,4};
        vt[11] = '{0,0,'h00, 0,0,'h00, 1,'h05,'h116,  0,1,'h40,0,0,4};
        vt[12] = '{0,0,'h00, 0,0,'h00, 1,'h05,'h116,  1,0,'h40,0,0,4};
        vt[13] = '{0,0,'h00, 0,0,'h00, 1,'h06,'h117,  1,0,'h40,0,0,4};
        vt[14] = '{0,0,'h00, 0,0,'h00, 1,'h40,'hABC,  0,0,'h40,0,0,4};
        vt[15] = '{0,0,'h00, 0,0,'h00, 1,'h40,'hABC,  1,0,'h40,1,0,4};
        vt[16] = '{0,1,'h22, 1,0,'h00, 1,'h41,'hABD,  0,0,'h40,0,0,5};
        vt[17] = '{1,1,'h33, 1,0,'h00, 1,'h41,'hABD,  0,0,'h40,0,1,5};
        vt[18] = '{0,0,'h00, 0,1,'h80, 1,'h41,'hABD,  0,0,'h40,0,1,5};
        vt[19] = '{0,0,'h00, 0,0,'h00, 0,'h00,'h000,  0,1,'h80,0,0,5};
        vt[20] = '{0,0,'h00, 0,0,'h00, 1,'h80,'h5A5,  0,0,'h80,0,0,5};
        vt[21] = '{0,0,'h00, 0,0,'h00, 1,'h80,'h5A5,  1,0,'h80,1,0,5};
        vt[22] = '{0,0,'h00, 0,1,'h55, 0,'h81,'h000,  0,0,'h80,0,0,6};
        vt[23] = '{0,1,'h10, 0,0,'h00, 1,'h81,'h5A6,  0,0,'h80,0,0,6};
        vt[24] = '{0,1,'h20, 0,0,'h00, 0,'h00,'h000,  0,1,'h10,0,0,6};
        vt[25] = '{0,0,'h00, 0,0,'h00, 1,'h10,'h222,  0,1,'h20,0,0,6};
        vt[26] = '{0,0,'h00, 0,0,'h00, 1,'h10,'h222,  1,0,'h20,0,0,6};
        vt[27] = '{0,0,'h00, 0,0,'h00, 1,'h20,'h333,  0,0,'h20,0,0,6};
        vt[28] = '{0,0,'h00, 0,0,'h00, 1,'h20,'h333,  1,0,'h20,1,0,6};

        // reset state while held
        #2;
        chk("rst_restart", fetch_restart_o, 0);
        chk("rst_raddr", fetch_restart_addr_o, 0);
        chk("rst_cnt", issued_count_o, 0);
        chk("rst_halted", halted_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_deque", fetch_deque_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            if (i > 0) @(negedge clk);
            stall_i = vt[i].stall[0]; branch_i = vt[i].br[0]; branch_addr_i = 8'(vt[i].baddr);
            halt_i = vt[i].halt[0]; start_i = vt[i].start[0]; start_addr_i = 8'(vt[i].saddr);
            fetch_ready_i = vt[i].rdy[0]; fetch_addr_i = 8'(vt[i].faddr);
            fetch_instr_i = 12'(vt[i].finstr);
            #1;
            chk($sformatf("v%0d_deque", i), fetch_deque_o, vt[i].deq);
            chk($sformatf("v%0d_restart", i), fetch_restart_o, vt[i].rst);
            chk($sformatf("v%0d_raddr", i), fetch_restart_addr_o, vt[i].raddr);
            chk($sformatf("v%0d_valid", i), instr_valid_o, vt[i].vld);
            chk($sformatf("v%0d_halted", i), halted_o, vt[i].hlt);
            chk($sformatf("v%0d_cnt", i), issued_count_o, vt[i].cnt);
            if (vt[i].vld != 0) begin
                chk($sformatf("v%0d_iaddr", i), instr_addr_o, vt[i].faddr);
                chk($sformatf("v%0d_instr", i), instr_o, vt[i].finstr);
            end
        end

        // reset asserted between edges while in WAIT
        @(negedge clk);
        idle_inputs(); branch_i = 1; branch_addr_i = 8'h30; fetch_ready_i = 0;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mw_restart", fetch_restart_o, 1);
        chk("mw_raddr", fetch_restart_addr_o, 'h30);
        chk("mw_cnt_pre", issued_count_o, 7);
        @(negedge clk);
        fetch_ready_i = 1; fetch_addr_i = 8'h99;
        #1;
        chk("mw_wait_deque", fetch_deque_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mw_rst_deque", fetch_deque_o, 0);
        chk("mw_rst_restart", fetch_restart_o, 0);
        chk("mw_rst_raddr", fetch_restart_addr_o, 0);
        chk("mw_rst_cnt", issued_count_o, 0);
        chk("mw_rst_valid", instr_valid_o, 0);
        chk("mw_rst_halted", halted_o, 0);
        @(negedge clk);
        rst_n = 1'b1; fetch_ready_i = 0;
        #1;
        chk("mw_boot0_restart", fetch_restart_o, 0);
        @(negedge clk);
        #1;
        chk("mw_boot1_restart", fetch_restart_o, 1);
        chk("mw_boot1_raddr", fetch_restart_addr_o, 0);

        // saturation: 20 accepted instructions on a 4-bit counter
        @(negedge clk);
        fetch_ready_i = 1; fetch_addr_i = 8'h00;
        #1;
        chk("sat_wait_match_deque", fetch_deque_o, 0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            fetch_addr_i = 8'(n);
            #1;
            chk($sformatf("sat%0d_deque", n), fetch_deque_o, 1);
            chk($sformatf("sat%0d_cnt", n), issued_count_o, (n > 15) ? 15 : n);
        end
        @(negedge clk);
        fetch_ready_i = 0;
        #1;
        chk("sat_final_cnt", issued_count_o, 'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
